// File: rtl/mem_byte_interface.sv
// mem_byte_interface: byte-serial big-endian RAM access handshaken by mfa/mfc.
module mem_byte_interface #(
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        mfa,
    input  logic        rw,
    input  logic [1:0]  mas,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mfc,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t st;
    logic rw_q, sgn_q;
    logic [1:0] mas_q, cnt;
    logic [31:0] wd, asm_q, r, ext;
    logic [AW-1:0] base, cur;
    logic [7:0] mem [DEPTH];
    logic [7:0] rd;
    logic last;
    logic unused_addr;
    assign unused_addr = ^addr[31:AW];
    assign cur = base + AW'(cnt);
    assign rd = mem[cur];
    assign last = cnt == (mas_q == 2'b01 ? 2'd3 : mas_q == 2'b10 ? 2'd1 : 2'd0);
    assign r = {asm_q[23:0], rd};
    assign ext = mas_q == 2'b01 ? r :
                 mas_q == 2'b10 ? {{16{sgn_q & r[15]}}, r[15:0]} :
                                  {{24{sgn_q & r[7]}}, r[7:0]};
    // Write data is pre-aligned to the top byte so every transfer takes wd[31:24].
    always_ff @(posedge clk)
        if (st == ACCESS && rw_q) mem[cur] <= wd[31:24];
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            st <= IDLE;
            mfc <= 1'b0;
            err <= 1'b0;
            data_out <= '0;
            cnt <= '0;
            rw_q <= 1'b0;
            sgn_q <= 1'b0;
            mas_q <= '0;
            wd <= '0;
            asm_q <= '0;
            base <= '0;
        end else begin
            case (st)
                IDLE: if (mfa) begin
                    rw_q <= rw;
                    mas_q <= mas;
                    sgn_q <= sgn;
                    base <= addr[AW-1:0] & ~AW'(mas == 2'b01 ? 3 : mas == 2'b10 ? 1 : 0);
                    wd <= mas == 2'b01 ? data_in :
                          mas == 2'b10 ? {data_in[15:0], 16'h0} : {data_in[7:0], 24'h0};
                    cnt <= '0;
                    asm_q <= '0;
                    if (mas == 2'b11) begin
                        st <= DONE;
                        mfc <= 1'b1;
                        err <= 1'b1;
                        data_out <= '0;
                    end else st <= ACCESS;
                end
                ACCESS: begin
                    wd <= wd << 8;
                    asm_q <= r;
                    cnt <= cnt + 2'd1;
                    if (last) begin
                        st <= DONE;
                        mfc <= 1'b1;
                        if (!rw_q) data_out <= ext;
                    end
                end
                DONE: if (!mfa) begin
                    st <= IDLE;
                    mfc <= 1'b0;
                    err <= 1'b0;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_byte_interface.sv
// tb_mem_byte_interface: table, hand-written and random checks against a byte-array model.
module tb_mem_byte_interface;
    localparam int DEPTH = 256;
    logic clk = 0, CLR = 0, mfa = 0, rw = 0, sgn = 0;
    logic [1:0] mas = 0;
    logic [31:0] addr = 0, data_in = 0, data_out;
    logic mfc, err;
    int checks = 0, errors = 0;
    logic [7:0] ref_mem [DEPTH];
    logic [31:0] ref_dout = 0;

    mem_byte_interface #(.DEPTH(DEPTH), .AW(8)) dut (
        .clk(clk), .CLR(CLR), .mfa(mfa), .rw(rw), .mas(mas), .sgn(sgn),
        .addr(addr), .data_in(data_in), .data_out(data_out), .mfc(mfc), .err(err));

    always #5 clk = ~clk;

    typedef struct {
        logic rw; logic [1:0] mas; logic sgn; logic [31:0] addr, data, exp_d; int exp_lat; logic exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: bytes stored MSB-first at (base+k) mod DEPTH; reads extend per size.
    task automatic model(input logic w, input logic [1:0] m, input logic s, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic e);
        int n, b;
        logic [31:0] v;
        n = m == 0 ? 1 : m == 1 ? 4 : m == 2 ? 2 : 0;
        e = m == 3;
        lat = n + 1;
        if (m == 3) begin
            ref_dout = 0;
            return;
        end
        b = int'(a % DEPTH) & ~(n - 1);
        v = 0;
        for (int k = 0; k < n; k++) begin
            if (w) ref_mem[(b + k) % DEPTH] = 8'((d >> (8 * (n - 1 - k))) & 255);
            else v = (v << 8) | 32'(ref_mem[(b + k) % DEPTH]);
        end
        if (!w) begin
            if (s && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
            ref_dout = v;
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] m, input logic s, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rw = w; mas = m; sgn = s; addr = a; data_in = d; mfa = 1;
    endtask

    task automatic wait_mfc(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mfc) return;
        end
        lat = -1;
    endtask

    task automatic drop(input string name);
        mfa = 0;
        rw = $urandom; mas = 2'($urandom); addr = $urandom; data_in = $urandom;
        @(posedge clk); #1;
        chk({name, " mfc_low"}, 32'(mfc), 0);
        chk({name, " err_low"}, 32'(err), 0);
    endtask

    task automatic run(input string name, input logic w, input logic [1:0] m, input logic s, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input int exp_lat, input logic exp_err);
        int lat;
        issue(w, m, s, a, d);
        wait_mfc(lat);
        chk({name, " lat"}, 32'(lat), 32'(exp_lat));
        chk({name, " data"}, data_out, exp_d);
        chk({name, " err"}, 32'(err), 32'(exp_err));
        drop(name);
    endtask

    task automatic run_model(input string name, input logic w, input logic [1:0] m, input logic s,
                             input logic [31:0] a, input logic [31:0] d);
        int lat;
        logic e;
        model(w, m, s, a, d, lat, e);
        run(name, w, m, s, a, d, ref_dout, lat, e);
    endtask

    initial begin
        vec_t tbl [13];
        int lat;
        logic e;
        tbl = '{
            '{1, 2'b01, 0, 32'h10,  32'hDEADBEEF, 32'h0,        5, 0},
            '{0, 2'b01, 0, 32'h13,  32'h0,        32'hDEADBEEF, 5, 0},
            '{0, 2'b00, 0, 32'h11,  32'h0,        32'h000000AD, 2, 0},
            '{0, 2'b00, 1, 32'h10,  32'h0,        32'hFFFFFFDE, 2, 0},
            '{0, 2'b10, 0, 32'h12,  32'h0,        32'h0000BEEF, 3, 0},
            '{0, 2'b10, 1, 32'h12,  32'h0,        32'hFFFFBEEF, 3, 0},
            '{1, 2'b01, 0, 32'h30,  32'h01020304, 32'hFFFFBEEF, 5, 0},
            '{1, 2'b11, 0, 32'h30,  32'hFFFFFFFF, 32'h0,        1, 1},
            '{0, 2'b01, 0, 32'h30,  32'h0,        32'h01020304, 5, 0},
            '{1, 2'b01, 0, 32'h104, 32'hCAFEF00D, 32'h01020304, 5, 0},
            '{0, 2'b01, 0, 32'h04,  32'h0,        32'hCAFEF00D, 5, 0},
            '{1, 2'b00, 0, 32'hFF,  32'h123456A5, 32'hCAFEF00D, 2, 0},
            '{0, 2'b00, 1, 32'hFF,  32'h0,        32'hFFFFFFA5, 2, 0}
        };
        #12 CLR = 1;
        #1;
        chk("reset mfc", 32'(mfc), 0);
        chk("reset err", 32'(err), 0);
        chk("reset data_out", data_out, 0);
        // Fill the RAM so every later read has a defined expectation.
        for (int i = 0; i < DEPTH; i += 4) begin
            logic [31:0] d = $urandom;
            model(1, 2'b01, 0, i, d, lat, e);
            issue(1, 2'b01, 0, i, d);
            wait_mfc(lat);
            mfa = 0;
            @(posedge clk); #1;
        end
        chk("fill data_out", data_out, 0);
        foreach (tbl[i]) begin
            run($sformatf("tbl%0d", i), tbl[i].rw, tbl[i].mas, tbl[i].sgn, tbl[i].addr, tbl[i].data,
                tbl[i].exp_d, tbl[i].exp_lat, tbl[i].exp_err);
            model(tbl[i].rw, tbl[i].mas, tbl[i].sgn, tbl[i].addr, tbl[i].data, lat, e);
        end
        // mfa held high after mfc: output stays, no restart.
        model(0, 2'b01, 0, 32'h10, 0, lat, e);
        issue(0, 2'b01, 0, 32'h10, 0);
        wait_mfc(lat);
        chk("hold lat", 32'(lat), 5);
        for (int i = 0; i < 5; i++) begin
            addr = $urandom; mas = 2'($urandom); rw = 1; data_in = $urandom;
            @(posedge clk); #1;
            chk($sformatf("hold mfc%0d", i), 32'(mfc), 1);
            chk($sformatf("hold data%0d", i), data_out, 32'hDEADBEEF);
        end
        drop("hold");
        // mfa pulsed low mid-access.
        issue(0, 2'b01, 0, 32'h04, 0);
        @(posedge clk); #1;
        mfa = 0;
        @(posedge clk); #1;
        mfa = 1;
        wait_mfc(lat);
        chk("pulse lat", 32'(lat), 3);
        chk("pulse data", data_out, 32'hCAFEF00D);
        drop("pulse");
        model(0, 2'b01, 0, 32'h04, 0, lat, e);
        // Reset two bytes into a word write.
        run_model("clr pre", 1, 2'b01, 0, 32'h20, 32'h0);
        issue(1, 2'b01, 0, 32'h20, 32'h11223344);
        repeat (3) @(posedge clk);
        #1 CLR = 0;
        #1;
        chk("clr mfc", 32'(mfc), 0);
        chk("clr data_out", data_out, 0);
        mfa = 0;
        #2 CLR = 1;
        ref_mem[8'h20] = 8'h11;
        ref_mem[8'h21] = 8'h22;
        ref_dout = 0;
        @(posedge clk); #1;
        chk("clr idle mfc", 32'(mfc), 0);
        run_model("clr read", 0, 2'b01, 0, 32'h20, 0);
        for (int i = 0; i < 200; i++)
            run_model($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
